// File: rtl/cla_mul_pkg.sv
// Shared types and default widths for the cla_mul_arbiter block.
// Optional build macro: CLA_MUL_PIPE_EN (adds a second product register stage).
package cla_mul_pkg;

    // FSM encoding; CLA_MUL_PIPE is only reachable when CLA_MUL_PIPE_EN is defined.
    typedef enum logic [1:0] {
        CLA_MUL_IDLE = 2'd0,
        CLA_MUL_MUL  = 2'd1,
        CLA_MUL_PIPE = 2'd2,
        CLA_MUL_RESP = 2'd3
    } cla_mul_state_e;

    localparam int CLA_MUL_MCAND_WID  = 32;
    localparam int CLA_MUL_MPLIER_WID = 32;

endpackage

// File: rtl/cla_mul_rr_arb.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping.
module cla_mul_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_vld
);

    // Scan offsets from farthest to nearest so the nearest asserted request wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                grant_idx = ID_W'(idx);
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_wb_cla_multiplier.sv
// Combinational unsigned multiplier with a full-width product.
module cpu_wb_cla_multiplier #(
    parameter int MULTICAND_WID  = 32,
    parameter int MULTIPLIER_WID = 32
) (
    input  logic [MULTICAND_WID-1:0]                multicand,
    input  logic [MULTIPLIER_WID-1:0]               multiplier,
    output logic [MULTICAND_WID+MULTIPLIER_WID-1:0] product
);

    // Both operands are zero-extended to the product width so nothing is truncated.
    assign product = {{MULTIPLIER_WID{1'b0}}, multicand} * {{MULTICAND_WID{1'b0}}, multiplier};

endmodule

// File: rtl/cla_mul_arbiter.sv
// Round-robin sharing of one combinational multiplier between NUM_REQ requesters.
// Build macro: CLA_MUL_PIPE_EN adds a PIPE state and second product register.
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid never waits on ready, and resp_product/resp_id hold while
// resp_valid is high and resp_ready is low.
module cla_mul_arbiter
    import cla_mul_pkg::*;
#(
    parameter int MULTICAND_WID  = CLA_MUL_MCAND_WID,
    parameter int MULTIPLIER_WID = CLA_MUL_MPLIER_WID,
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_REQ-1:0]                      req_valid,
    output logic [NUM_REQ-1:0]                      req_ready,
    input  logic [NUM_REQ*MULTICAND_WID-1:0]        req_multicand,
    input  logic [NUM_REQ*MULTIPLIER_WID-1:0]       req_multiplier,
    output logic                                    resp_valid,
    input  logic                                    resp_ready,
    output logic [ID_W-1:0]                         resp_id,
    output logic [MULTICAND_WID+MULTIPLIER_WID-1:0] resp_product,
    output logic                                    busy,
    output cla_mul_state_e                          dbg_state
);

    localparam int PW = MULTICAND_WID + MULTIPLIER_WID;

    cla_mul_state_e            state_q;
    logic [ID_W-1:0]           rr_ptr_q;
    logic [ID_W-1:0]           rr_ptr_d;
    logic [MULTICAND_WID-1:0]  op_a_q;
    logic [MULTIPLIER_WID-1:0] op_b_q;
    logic [ID_W-1:0]           id_q;
    logic [PW-1:0]             prod_q;
    logic                      resp_valid_q;
    logic                      busy_q;
    logic [ID_W-1:0]           grant_idx;
    logic                      grant_vld;
    logic [MULTICAND_WID-1:0]  sel_a;
    logic [MULTIPLIER_WID-1:0] sel_b;
    logic [PW-1:0]             mul_out;
`ifdef CLA_MUL_PIPE_EN
    logic [PW-1:0]             prod2_q;
`endif

    cla_mul_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    cpu_wb_cla_multiplier #(
        .MULTICAND_WID  (MULTICAND_WID),
        .MULTIPLIER_WID (MULTIPLIER_WID)
    ) u_mul (
        .multicand  (op_a_q),
        .multiplier (op_b_q),
        .product    (mul_out)
    );

    // Operand mux for the granted requester and the pointer value after it.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a = req_multicand[i*MULTICAND_WID +: MULTICAND_WID];
                sel_b = req_multiplier[i*MULTIPLIER_WID +: MULTIPLIER_WID];
            end
        end
        rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Accept is offered only in IDLE, to the single granted requester.
    always_comb begin
        req_ready = '0;
        if (state_q == CLA_MUL_IDLE && grant_vld) req_ready[grant_idx] = 1'b1;
    end

    // Transaction FSM with registered response and busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CLA_MUL_IDLE;
            rr_ptr_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            id_q         <= '0;
            prod_q       <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef CLA_MUL_PIPE_EN
            prod2_q      <= '0;
`endif
        end else begin
            case (state_q)
                CLA_MUL_IDLE: begin
                    if (grant_vld) begin
                        op_a_q   <= sel_a;
                        op_b_q   <= sel_b;
                        id_q     <= grant_idx;
                        rr_ptr_q <= rr_ptr_d;
                        busy_q   <= 1'b1;
                        state_q  <= CLA_MUL_MUL;
                    end
                end
                CLA_MUL_MUL: begin
                    prod_q <= mul_out;
`ifdef CLA_MUL_PIPE_EN
                    state_q <= CLA_MUL_PIPE;
`else
                    resp_valid_q <= 1'b1;
                    state_q      <= CLA_MUL_RESP;
`endif
                end
`ifdef CLA_MUL_PIPE_EN
                CLA_MUL_PIPE: begin
                    prod2_q      <= prod_q;
                    resp_valid_q <= 1'b1;
                    state_q      <= CLA_MUL_RESP;
                end
`endif
                CLA_MUL_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= CLA_MUL_IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= CLA_MUL_IDLE;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = id_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;
`ifdef CLA_MUL_PIPE_EN
    assign resp_product = prod2_q;
`else
    assign resp_product = prod_q;
`endif

endmodule

// File: tb/tb_cla_mul_arbiter.sv
// Self-checking bench for cla_mul_arbiter: directed table, corner sequences, random traffic.
module tb_cla_mul_arbiter;
    import cla_mul_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int BW = 32;
    localparam int PW = 64;
    localparam int IW = 2;
`ifdef CLA_MUL_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_multicand = '0;
    logic [N*BW-1:0]   req_multiplier = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [IW-1:0]     resp_id;
    logic [PW-1:0]     resp_product;
    logic              busy;
    cla_mul_state_e    dbg_state;

    cla_mul_arbiter #(
        .MULTICAND_WID  (AW),
        .MULTIPLIER_WID (BW),
        .NUM_REQ        (N)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_multicand  (req_multicand),
        .req_multiplier (req_multiplier),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_product   (resp_product),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int model_ptr = 0;
    logic [AW-1:0] ma[N];
    logic [BW-1:0] mb[N];

    typedef struct {
        int        id;
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic [PW-1:0] exp;
    } vec_t;
    vec_t vt[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_multicand[i*AW +: AW]  = ma[i];
            req_multiplier[i*BW +: BW] = mb[i];
        end
    endtask

    // Reference arbitration: first valid requester at or after the pointer, modulo N.
    function automatic int model_pick(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++)
            if (mask[(model_ptr + k) % N]) return (model_ptr + k) % N;
        return -1;
    endfunction

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst req_ready", 64'(req_ready), 64'd0);
        chk("rst resp_valid", 64'(resp_valid), 64'd0);
        chk("rst resp_id", 64'(resp_id), 64'd0);
        chk("rst resp_product", resp_product, 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst state", 64'(dbg_state), 64'(CLA_MUL_IDLE));
        rst_n     = 1'b1;
        model_ptr = 0;
        @(negedge clk);
    endtask

    // One transaction; call and return at a falling edge.
    task automatic txn(input string tag, input logic [N-1:0] mask, input int stall,
                       input bit keep, output logic [PW-1:0] got_p, output int got_id);
        int exp_id, cyc, lat;
        bit ready_leak, unstable;
        logic [PW-1:0] exp_p;
        got_p  = '0;
        got_id = -1;
        exp_id = model_pick(mask);
        exp_p  = PW'(ma[exp_id]) * PW'(mb[exp_id]);
        drive_ops();
        req_valid  = mask;
        resp_ready = (stall == 0);
        #1;
        cyc = 0;
        while (req_ready == '0 && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (req_ready == '0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s ready timeout: got req_ready=0 expected a grant", tag);
            req_valid = '0;
            @(negedge clk);
            return;
        end
        chk({tag, " grant"}, 64'(req_ready), 64'd1 << exp_id);
        model_ptr = (exp_id + 1) % N;
        @(posedge clk);
        lat = 0;
        ready_leak = 1'b0;
        do begin
            @(negedge clk);
            #1;
            lat++;
            if (req_ready != '0) ready_leak = 1'b1;
        end while (!resp_valid && lat < 10);
        chk({tag, " latency"}, 64'(lat), 64'(LAT));
        chk({tag, " no ready busy"}, 64'(ready_leak), 64'd0);
        chk({tag, " resp_id"}, 64'(resp_id), 64'(exp_id));
        chk({tag, " product"}, resp_product, exp_p);
        got_p  = resp_product;
        got_id = int'(resp_id);
        if (stall > 0) begin
            unstable  = 1'b0;
            req_valid = '1;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                #1;
                if (!resp_valid || resp_product !== exp_p || resp_id !== IW'(exp_id) ||
                    req_ready != '0)
                    unstable = 1'b1;
            end
            chk({tag, " stall hold"}, 64'(unstable), 64'd0);
            req_valid  = mask;
            resp_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, " post resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, " post busy"}, 64'(busy), 64'd0);
        if (!keep) req_valid = '0;
    endtask

    initial begin
        logic [PW-1:0] p;
        int id, cnt;
        for (int i = 0; i < N; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        vt[0] = '{0, 32'h0000_7FFF, 32'h0000_007F, 64'h3F_7F81};
        vt[1] = '{2, 32'h0000_8FF0, 32'h0000_00F0, 64'h86_F100};
        vt[2] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vt[3] = '{3, 32'h0000_FFFF, 32'h0000_00FF, 64'hFE_FF01};
        vt[4] = '{0, 32'h0000_0000, 32'h1234_5678, 64'h0};
        vt[5] = '{2, 32'h8000_0000, 32'h0000_0002, 64'h1_0000_0000};

        @(negedge clk);
        do_reset();

        // Directed table, one requester at a time.
        for (int v = 0; v < 6; v++) begin
            ma[vt[v].id] = vt[v].a;
            mb[vt[v].id] = vt[v].b;
            txn($sformatf("vec%0d", v), 4'b1 << vt[v].id, 0, 1'b0, p, id);
            chk($sformatf("vec%0d table product", v), p, vt[v].exp);
            chk($sformatf("vec%0d table id", v), 64'(id), 64'(vt[v].id));
        end

        // Back-pressure: requester 2 held in RESP for 5 cycles.
        ma[2] = 32'h0000_8FF0;
        mb[2] = 32'h0000_00F0;
        txn("stall", 4'b0100, 5, 1'b0, p, id);
        chk("stall table product", p, 64'h86_F100);

        // All requesters valid continuously: grants 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < N; i++) begin
            ma[i] = AW'(i + 1);
            mb[i] = 32'h10;
        end
        for (int t = 0; t < 5; t++) begin
            txn($sformatf("rr%0d", t), 4'b1111, 0, 1'b1, p, id);
            chk($sformatf("rr%0d order", t), 64'(id), 64'(t % N));
            chk($sformatf("rr%0d table product", t), p, 64'((t % N + 1) * 16));
        end
        req_valid = '0;

        // Reset while in MUL drops the transaction.
        ma[0] = 32'h1234;
        mb[0] = 32'h5678;
        drive_ops();
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        #1;
        chk("midrst grant", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("midrst in MUL", 64'(dbg_state), 64'(CLA_MUL_MUL));
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst product", resp_product, 64'd0);
        chk("midrst resp_id", 64'(resp_id), 64'd0);
        chk("midrst state", 64'(dbg_state), 64'(CLA_MUL_IDLE));
        @(negedge clk);
        rst_n     = 1'b1;
        model_ptr = 0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (resp_valid) cnt++;
        end
        chk("midrst no response", 64'(cnt), 64'd0);

        // Pointer follows the last grant: 1, then only 3, then pointer wrapped to 0.
        ma[1] = 32'd5;  mb[1] = 32'd6;
        ma[3] = 32'd7;  mb[3] = 32'd9;
        txn("ptr a", 4'b0010, 0, 1'b0, p, id);
        txn("ptr b", 4'b1000, 0, 1'b0, p, id);
        chk("ptr b id", 64'(id), 64'd3);
        txn("ptr c", 4'b1010, 0, 1'b0, p, id);
        chk("ptr wrapped", 64'(id), 64'd1);

        // Random traffic against the reference model.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                ma[i] = $urandom;
                mb[i] = $urandom;
            end
            txn($sformatf("rnd%0d", t), N'($urandom_range(1, 15)), $urandom_range(0, 3),
                1'b0, p, id);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/cla_mul_arbiter.md
# cla_mul_arbiter

Shares one `cpu_wb_cla_multiplier` instance (combinational 32x32 CLA multiplier) between `NUM_REQ` requesters. Requests are selected round-robin, with operands and product registered around the multiplier. Results return on a single tagged response channel with valid/ready back-pressure. The block sits between CPU-side functional units and the multiplier datapath.

## Interface
- `MULTICAND_WID`, 32, multiplicand width
- `MULTIPLIER_WID`, 32, multiplier width
- `NUM_REQ`, 4, number of requesters (2..8)
- `ID_W`, `$clog2(NUM_REQ)`, response tag width (derived)

Ports:
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req_valid` in NUM_REQ: per-requester request valid
- `req_ready` out NUM_REQ: per-requester accept, one-hot or zero
- `req_multicand` in NUM_REQ*MULTICAND_WID: packed operands, requester i at slice i
- `req_multiplier` in NUM_REQ*MULTIPLIER_WID: packed operands, requester i at slice i
- `resp_valid` out 1: product available
- `resp_ready` in 1: consumer accepts product
- `resp_id` out ID_W: index of the requester that owns the product
- `resp_product` out MULTICAND_WID+MULTIPLIER_WID: unsigned product
- `busy` out 1: high in any state other than IDLE

## Operation
- FSM states: IDLE, MUL, (PIPE when `CLA_MUL_PIPE_EN`), RESP.
- **IDLE:**
  - The arbiter picks the first asserted `req_valid` starting at `rr_ptr` and wrapping modulo NUM_REQ.
  - `req_ready[grant]` is driven combinationally, only in IDLE.
  - On handshake: latch operands and `grant` into `op_a`, `op_b`, `id_q`; set `rr_ptr <= (grant+1) % NUM_REQ`; go to MUL.
- **MUL:** capture the multiplier output (from `op_a`, `op_b`) into `prod_q`. Go to RESP, or to PIPE if enabled.
- **PIPE:** second product register stage. Then go to RESP.
- **RESP:** `resp_valid=1`. Hold `resp_product` and `resp_id` stable until `resp_ready`. On handshake go to IDLE.
- Arithmetic:
  - Unsigned; full-width product, no truncation.
  - Wrap-around operands (all ones) give exact 2N-bit results.
- `rr_ptr` changes only on an accepted request. Idle cycles do not move it.
- A requester that drops `req_valid` before it is granted loses nothing; no state is kept for it.
- `req_valid` while not in IDLE: `req_ready` stays 0 and the request is not latched.

## Timing
- Reset (async assert, sync deassert expected upstream):
  - State: IDLE.
  - `rr_ptr=0`, `req_ready=0`, `resp_valid=0`, `resp_id=0`, `resp_product=0`, `busy=0`.
  - Operand and product registers: 0.
- Request accepted at edge T: `resp_valid` rises after edge T+1 (T+2 with PIPE).
- Latency: 2 cycles accept-to-valid (3 with PIPE).
- Throughput:
  - Minimum 3 cycles per transaction (4 with PIPE) when `resp_ready` is held high.
  - The next accept happens in the cycle after the response handshake.
- `resp_ready` low: the block stalls in RESP indefinitely and accepts nothing.
- Reset asserted mid-operation: the in-flight transaction is discarded; no `resp_valid` is issued for it.
- Simultaneous requests: exactly one grant per IDLE cycle; others wait.

## Configuration
- Macro: `CLA_MUL_PIPE_EN`.
- Defined: PIPE state and a second product register are compiled in; latency 3; suits targets where the CLA multiplier misses timing in one cycle.
- Undefined: no PIPE state; latency 2.

## Structure
- Package `cla_mul_pkg`:
  - FSM state enum (`CLA_MUL_IDLE`, `CLA_MUL_MUL`, `CLA_MUL_PIPE`, `CLA_MUL_RESP`).
  - Default width constants `CLA_MUL_MCAND_WID=32`, `CLA_MUL_MPLIER_WID=32`.
- One sub-module, `cla_mul_rr_arb`:
  - Parameterised NUM_REQ round-robin picker.
  - Inputs: `req`, `ptr`. Outputs: `grant_idx`, `grant_vld`.
  - Purely combinational.
- The multiplier is instantiated as existing `cpu_wb_cla_multiplier`.

## Test plan
- Reset, then requester 0 sends 0x00007FFF x 0x0000007F with `resp_ready=1` -> `resp_product=0x3F7F81`, `resp_id=0`, `resp_valid` 2 cycles after accept (3 with PIPE).
- All 4 requesters valid continuously with operands i+1 x 0x10 -> grants in order 0,1,2,3,0; products 0x10, 0x20, 0x30, 0x40; `rr_ptr` wraps.
- Requester 2 sends 0x00008FF0 x 0x000000F0; hold `resp_ready=0` for 5 cycles -> `resp_product=0x86F100` and `resp_id=2` stable, all `req_ready=0` throughout.
- 0xFFFFFFFF x 0xFFFFFFFF -> `resp_product=0xFFFFFFFE00000001`; 0x0000FFFF x 0x000000FF -> 0xFEFF01.
- Assert `rst_n` low in MUL state -> all outputs return to reset values immediately; after release, no `resp_valid` for the dropped request.
- Only requester 3 valid, after a grant to requester 1 -> requester 3 granted; `rr_ptr` becomes 0.
